// File: rtl/task_15_step_analyzer_if.sv
// Boundary between the step analyzer and the closed loop / host.
// Carries setpoint, loop sample, run control and measurement results.
// Combinational wires only; no storage.
interface task_15_step_analyzer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [15:0]      step_amp;
    logic [15:0]      y_port;
    logic             y_valid;
    logic [15:0]      u_port;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             err;
    logic [CNT_W-1:0] rise_cycles;
    logic [CNT_W-1:0] settle_cycles;
    logic [15:0]      peak_value;
    logic [16:0]      overshoot;

    // Analyzer side: drives the setpoint and results, consumes loop output.
    modport master (
        input  start, abort, step_amp, y_port, y_valid,
        output u_port, busy, done, timeout, err,
               rise_cycles, settle_cycles, peak_value, overshoot
    );

    // Loop/host side: the mirror image.
    modport slave (
        output start, abort, step_amp, y_port, y_valid,
        input  u_port, busy, done, timeout, err,
               rise_cycles, settle_cycles, peak_value, overshoot
    );
endinterface

// File: rtl/task_15_step_analyzer.sv
// Step-response engine: applies a setpoint step, measures rise/peak/overshoot/settle.
// Latency: u_port steps 1 cycle after start; done 1 cycle after the deciding sample.
// Backpressure: none; samples are taken whenever enb & y_valid, enb=0 freezes everything.
module task_15_step_analyzer #(
    parameter int CNT_W       = 16,
    parameter int SETTLE_TOL  = 164,
    parameter int SETTLE_HOLD = 32,
    parameter int MAX_SAMPLES = 4095
) (
    input  logic                     clk,
    input  logic                     reset_x,
    input  logic                     enb,
    task_15_step_analyzer_if.master  bus
);
    localparam int RUN_W = $clog2(SETTLE_HOLD + 1);
    localparam logic signed [16:0] TOL_P = 17'(SETTLE_TOL);
    localparam logic signed [16:0] TOL_N = -17'(SETTLE_TOL);

    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_target;
    logic [15:0]        r_u;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_err;
    logic               r_risen;
    logic [CNT_W-1:0]   r_rise;
    logic [CNT_W-1:0]   r_settle;
    logic [CNT_W-1:0]   r_settle_start;
    logic [CNT_W-1:0]   r_n;
    logic [RUN_W-1:0]   r_run;
    logic [15:0]        r_peak;
    logic [16:0]        r_ovs;

    logic               w_idle_like;
    logic               w_start_ok;
    logic               w_sample;
    logic signed [16:0] w_tgt17;
    logic signed [16:0] w_y17;
    logic signed [16:0] w_thr;
    logic signed [16:0] w_diff;
    logic               w_inband;
    logic [RUN_W-1:0]   w_run_inc;
    logic               w_settle_hit;
    logic               w_to_hit;
    logic [15:0]        w_peak_nxt;
    logic signed [16:0] w_ovs_raw;
    logic [16:0]        w_ovs;

    // All arithmetic is done in 17 bits so target/threshold/difference never wrap.
    assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_ok   = $signed(bus.step_amp) > 16'sd0;
    assign w_sample     = (r_state == ST_MEASURE) && bus.y_valid && !bus.abort;
    assign w_tgt17      = {r_target[15], r_target};
    assign w_y17        = {bus.y_port[15], bus.y_port};
    assign w_thr        = w_tgt17 - (w_tgt17 >>> 3);
    assign w_diff       = w_y17 - w_tgt17;
    assign w_inband     = (w_diff <= TOL_P) && (w_diff >= TOL_N);
    assign w_run_inc    = r_run + 1'b1;
    // Settling takes priority when it lands on the last budgeted sample.
    assign w_settle_hit = w_sample && w_inband && (w_run_inc == RUN_W'(SETTLE_HOLD));
    assign w_to_hit     = w_sample && !w_settle_hit && (r_n == CNT_W'(MAX_SAMPLES - 1));
    assign w_peak_nxt   = ($signed(bus.y_port) > $signed(r_peak)) ? bus.y_port : r_peak;
    assign w_ovs_raw    = $signed({w_peak_nxt[15], w_peak_nxt}) - w_tgt17;
    assign w_ovs        = w_ovs_raw[16] ? 17'd0 : w_ovs_raw;

    // State register.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            r_state <= ST_IDLE;
        end else if (enb) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: abort beats everything, start only honoured outside MEASURE.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        w_state_nxt = w_start_ok ? ST_MEASURE : ST_DONE;
                    end
                end
                ST_MEASURE: begin
                    if (w_settle_hit || w_to_hit) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Setpoint, run bookkeeping and measurement results.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            r_target       <= '0;
            r_u            <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_err          <= 1'b0;
            r_risen        <= 1'b0;
            r_rise         <= '1;
            r_settle       <= '1;
            r_settle_start <= '0;
            r_n            <= '0;
            r_run          <= '0;
            r_peak         <= 16'h8000;
            r_ovs          <= '0;
        end else if (enb) begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_u    <= '0;
                r_busy <= 1'b0;
            end else if (w_idle_like) begin
                if (bus.start && w_start_ok) begin
                    r_target       <= bus.step_amp;
                    r_u            <= bus.step_amp;
                    r_busy         <= 1'b1;
                    r_timeout      <= 1'b0;
                    r_err          <= 1'b0;
                    r_risen        <= 1'b0;
                    r_rise         <= '1;
                    r_settle       <= '1;
                    r_settle_start <= '0;
                    r_n            <= '0;
                    r_run          <= '0;
                    r_peak         <= 16'h8000;
                    r_ovs          <= '0;
                end else if (bus.start) begin
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end
            end else if (w_sample) begin
                r_n    <= r_n + 1'b1;
                r_peak <= w_peak_nxt;
                r_ovs  <= w_ovs;
                r_run  <= w_inband ? w_run_inc : '0;
                if (!r_risen && (w_y17 >= w_thr)) begin
                    r_rise  <= r_n;
                    r_risen <= 1'b1;
                end
                if (w_inband && (r_run == '0)) begin
                    r_settle_start <= r_n;
                end
                if (w_settle_hit) begin
                    r_settle <= (r_run == '0) ? r_n : r_settle_start;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end else if (w_to_hit) begin
                    r_timeout <= 1'b1;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
            end
        end
    end

    assign bus.u_port        = r_u;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.timeout       = r_timeout;
    assign bus.err           = r_err;
    assign bus.rise_cycles   = r_rise;
    assign bus.settle_cycles = r_settle;
    assign bus.peak_value    = r_peak;
    assign bus.overshoot     = r_ovs;
endmodule

// File: tb/tb_task_15_step_analyzer.sv
// Bench for the step analyzer: scripted and random trajectories against a sequence model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_task_15_step_analyzer;
    logic clk;
    logic reset_x;
    logic enb;

    task_15_step_analyzer_if #(.CNT_W(16)) bus ();

    task_15_step_analyzer dut (
        .clk     (clk),
        .reset_x (reset_x),
        .enb     (enb),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Trajectory the loop will present, indexed by sample number.
    int ys [4095];
    // Expected results from the model.
    int e_rise, e_settle, e_peak, e_ovs, e_to, e_d;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scan the whole trajectory: decision point is the end of the first 32-long
    // in-band stretch, or sample 4094 if none exists by then.
    task automatic model(input int tgt);
        int thr;
        int run;
        int dv;
        thr      = tgt - tgt / 8;
        run      = 0;
        e_d      = -1;
        e_settle = 65535;
        e_to     = 0;
        for (int n = 0; n < 4095; n++) begin
            dv  = ys[n] - tgt;
            run = (dv <= 164 && dv >= -164) ? run + 1 : 0;
            if (run == 32) begin
                e_d      = n;
                e_settle = n - 31;
                break;
            end
        end
        if (e_d < 0) begin
            e_d  = 4094;
            e_to = 1;
        end
        e_rise = 65535;
        e_peak = -32768;
        for (int n = 0; n <= e_d; n++) begin
            if (e_rise == 65535 && ys[n] >= thr) e_rise = n;
            if (ys[n] > e_peak) e_peak = ys[n];
        end
        e_ovs = (e_peak > tgt) ? e_peak - tgt : 0;
    endtask

    task automatic fill_plant(input int tgt, input int dly);
        for (int n = 0; n < 4095; n++) ys[n] = (n < dly) ? 0 : tgt;
    endtask

    task automatic fill_random(input int tgt);
        int m;
        int v;
        int thr;
        m   = $urandom_range(0, 40);
        thr = tgt - tgt / 8;
        for (int n = 0; n < 4095; n++) begin
            if (n < m) begin
                v = tgt * n / m + int'($urandom_range(0, 4000)) - 2000;
                if (n == m - 1) v = thr - int'($urandom_range(0, 1));
            end else begin
                v = tgt + int'($urandom_range(0, 330)) - 165;
            end
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            ys[n] = v;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_u"},       bus.u_port, 0);
        chk({tag, "_busy"},    bus.busy, 0);
        chk({tag, "_done"},    bus.done, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
        chk({tag, "_err"},     bus.err, 0);
        chk({tag, "_rise"},    bus.rise_cycles, 65535);
        chk({tag, "_settle"},  bus.settle_cycles, 65535);
        chk({tag, "_peak"},    bus.peak_value, 32768);
        chk({tag, "_ovs"},     bus.overshoot, 0);
    endtask

    task automatic bad_start(input string tag, input logic [15:0] amp, input int exp_u);
        enb = 1'b1;
        bus.step_amp = amp;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_err"},  bus.err, 1);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_u"},    bus.u_port, exp_u);
        chk({tag, "_busy"}, bus.busy, 0);
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, bus.done, 0);
        chk({tag, "_busy2"},    bus.busy, 0);
    endtask

    // One run: accepted start, then samples with random gaps (and random enb
    // if asked), optional abort after abort_at samples; results vs the model.
    task automatic run_case(input string tag, input int tgt, input bit enb_rand,
                            input int vprob, input int abort_at);
        int  k;
        int  cyc;
        bit  got;
        bit  v;
        bit  ab;
        int  thr;
        int  a_rise;
        int  a_peak;
        model(tgt);
        enb = 1'b1;
        bus.y_valid = 1'b0;
        bus.step_amp = 16'(tgt);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_u_step"},    bus.u_port, tgt);
        chk({tag, "_busy_on"},   bus.busy, 1);
        chk({tag, "_err_clr"},   bus.err, 0);
        chk({tag, "_to_clr"},    bus.timeout, 0);
        chk({tag, "_rise_clr"},  bus.rise_cycles, 65535);
        chk({tag, "_peak_clr"},  bus.peak_value, 32768);
        k   = 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20000) begin
            ab = (abort_at >= 0) && (k == abort_at);
            enb = ab ? 1'b1 : (enb_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            v   = ab ? 1'b0 : (int'($urandom_range(0, 99)) < vprob);
            bus.y_valid = v;
            bus.y_port  = 16'(ys[(k < 4095) ? k : 4094]);
            bus.abort   = ab;
            bus.start   = ab ? 1'b1 : ($urandom_range(0, 15) == 0);
            bus.step_amp = ab ? 16'h0123 : 16'($urandom);
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (ab) begin
                thr    = tgt - tgt / 8;
                a_rise = 65535;
                a_peak = -32768;
                for (int n = 0; n < abort_at; n++) begin
                    if (a_rise == 65535 && ys[n] >= thr) a_rise = n;
                    if (ys[n] > a_peak) a_peak = ys[n];
                end
                chk({tag, "_abort_u"},    bus.u_port, 0);
                chk({tag, "_abort_busy"}, bus.busy, 0);
                chk({tag, "_abort_done"}, bus.done, 0);
                chk({tag, "_abort_rise"}, bus.rise_cycles, a_rise);
                chk({tag, "_abort_peak"}, $signed(bus.peak_value), a_peak);
                bus.y_valid = 1'b0;
                return;
            end
            if (enb && v) k++;
            if (bus.done) got = 1'b1;
            cyc++;
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_n_at_done"}, k, e_d + 1);
        chk({tag, "_rise"},      bus.rise_cycles, e_rise);
        chk({tag, "_settle"},    bus.settle_cycles, e_settle);
        chk({tag, "_peak"},      $signed(bus.peak_value), e_peak);
        chk({tag, "_ovs"},       bus.overshoot, e_ovs);
        chk({tag, "_timeout"},   bus.timeout, e_to);
        chk({tag, "_busy_off"},  bus.busy, 0);
        chk({tag, "_u_hold"},    bus.u_port, tgt);
        enb = 1'b1;
        bus.y_valid = 1'b1;
        bus.y_port  = 16'h7FFF;
        @(posedge clk); #1;
        bus.y_valid = 1'b0;
        chk({tag, "_done_pulse"},  bus.done, 0);
        chk({tag, "_peak_stable"}, $signed(bus.peak_value), e_peak);
    endtask

    initial begin
        reset_x      = 1'b1;
        enb          = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.step_amp = '0;
        bus.y_port   = '0;
        bus.y_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        reset_x = 1'b0;
        @(posedge clk); #1;

        // Non-positive step amplitudes from IDLE leave the setpoint at 0.
        bad_start("neg", 16'hE000, 0);
        bad_start("zero", 16'h0000, 0);

        // Plant = setpoint delayed by 3 samples.
        fill_plant(16'h2000, 3);
        run_case("plant", 16'h2000, 1'b0, 100, -1);
        chk("plant_rise_const", bus.rise_cycles, 3);
        chk("plant_settle_const", bus.settle_cycles, 3);

        // Rejected start from DONE: setpoint keeps the old target.
        bad_start("neg_done", 16'h0000, 16'h2000);

        // Scripted overshoot trajectory.
        fill_plant(16'h2000, 0);
        ys[0] = 0; ys[1] = 16'h1000; ys[2] = 16'h2400; ys[3] = 16'h1F00;
        run_case("script", 16'h2000, 1'b0, 80, -1);
        chk("script_ovs_const", bus.overshoot, 16'h0400);

        // Output stuck at 0: runs out the sample budget.
        fill_plant(0, 0);
        run_case("stuck", 16'h4000, 1'b0, 100, -1);
        chk("stuck_to_const", bus.timeout, 1);

        // Settling completes exactly on the last budgeted sample.
        fill_plant(16'h1000, 4063);
        run_case("edge", 16'h1000, 1'b0, 100, -1);
        chk("edge_to_const", bus.timeout, 0);

        // Abort mid-run, then an independent second run.
        fill_plant(16'h3000, 3);
        run_case("abort1", 16'h3000, 1'b0, 70, 10);
        fill_plant(16'h1000, 3);
        run_case("abort2", 16'h1000, 1'b0, 70, -1);

        // Smallest positive step.
        fill_random(1);
        run_case("tiny", 1, 1'b1, 70, -1);

        // Random trajectories, with and without enable gaps.
        for (int i = 0; i < 6; i++) begin
            int tgt;
            tgt = $urandom_range(1, 32767);
            fill_random(tgt);
            run_case($sformatf("rnd%0d", i), tgt, i[0], 70, -1);
        end

        // Asynchronous reset in the middle of a run.
        fill_plant(16'h2000, 3);
        enb = 1'b1;
        bus.step_amp = 16'h2000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            enb = ($urandom_range(0, 1) == 1);
            bus.y_valid = ($urandom_range(0, 3) != 0);
            bus.y_port  = 16'h2000;
            @(posedge clk); #1;
        end
        #2;
        reset_x = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        reset_x = 1'b0;
        bus.y_valid = 1'b0;
        @(posedge clk); #1;
        begin
            int tgt;
            tgt = $urandom_range(1, 32767);
            fill_random(tgt);
            run_case("postrst", tgt, 1'b1, 60, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
